// File: rtl/logic_unit_acc_if.sv
// Handshake bundle for logic_unit_acc.
// Flag signals exist only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_acc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, a, b, op, use_acc,
    output out_ready,
    input  in_ready, out_valid, y,
    input  zero, parity
  );

  modport slave (
    input  in_valid, a, b, op, use_acc,
    input  out_ready,
    output in_ready, out_valid, y,
    output zero, parity
  );
`else
  modport master (
    output in_valid, a, b, op, use_acc,
    output out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, op, use_acc,
    input  out_ready,
    output in_ready, out_valid, y
  );
`endif
endinterface

// File: rtl/logic_unit_acc.sv
// Registered 8-op bitwise unit with chaining accumulator.
// Optional zero/parity flags: define LOGIC_UNIT_FLAGS_EN.
module logic_unit_acc #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  logic_unit_acc_if.slave bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r;
  logic             fire;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             zero_q, zero_d;
  logic             par_q, par_d;
`endif

  assign bus.in_ready  = ~vld_q | bus.out_ready;
  assign bus.out_valid = vld_q;
  assign bus.y         = y_q;
`ifdef LOGIC_UNIT_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.parity    = par_q;
`endif

  assign fire = bus.in_valid & bus.in_ready;
  assign ea   = bus.use_acc ? acc_q : bus.a;

  always_comb begin
    r0 = '0;
    unique case (bus.op[1:0])
      2'b00: r0 = ea | bus.b;
      2'b01: r0 = ea & bus.b;
      2'b10: r0 = ea ^ bus.b;
      2'b11: r0 = ~ea;
      default: r0 = '0;
    endcase
    r = bus.op[2] ? ~r0 : r0;
  end

  always_comb begin
    y_d    = y_q;
    acc_d  = acc_q;
    vld_d  = vld_q;
`ifdef LOGIC_UNIT_FLAGS_EN
    zero_d = zero_q;
    par_d  = par_q;
`endif
    if (fire) begin
      y_d    = r;
      acc_d  = r;
      vld_d  = 1'b1;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_d = (r == '0);
      par_d  = ^r;
`endif
    end else if (bus.out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_q <= 1'b0;
      par_q  <= 1'b0;
`endif
    end else begin
      y_q    <= y_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_q <= zero_d;
      par_q  <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed vector bench for logic_unit_acc (WIDTH=8).
// Flag checks are compiled in with LOGIC_UNIT_FLAGS_EN.
module tb_logic_unit_acc;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic_unit_acc_if #(.WIDTH(8)) bus ();

  logic_unit_acc #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       use_acc;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [2:0] op,
                       input logic       ua);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.use_acc  = ua;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{8'hF0, 8'h3C, 3'b000, 1'b0, 8'hFC};
    vec[1]  = '{8'hF0, 8'h3C, 3'b001, 1'b0, 8'h30};
    vec[2]  = '{8'hF0, 8'h3C, 3'b010, 1'b0, 8'hCC};
    vec[3]  = '{8'hF0, 8'h3C, 3'b011, 1'b0, 8'h0F};
    vec[4]  = '{8'hF0, 8'h3C, 3'b100, 1'b0, 8'h03};
    vec[5]  = '{8'hF0, 8'h3C, 3'b101, 1'b0, 8'hCF};
    vec[6]  = '{8'hF0, 8'h3C, 3'b110, 1'b0, 8'h33};
    vec[7]  = '{8'hF0, 8'h3C, 3'b111, 1'b0, 8'hF0};
    vec[8]  = '{8'hAA, 8'h00, 3'b111, 1'b0, 8'hAA};
    vec[9]  = '{8'h00, 8'hFF, 3'b010, 1'b1, 8'h55};
    vec[10] = '{8'h00, 8'h0F, 3'b001, 1'b1, 8'h05};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.use_acc   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("rst_y", bus.y, 8'h00);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("rst_zero", {7'b0, bus.zero}, 8'h00);
    chk("rst_parity", {7'b0, bus.parity}, 8'h00);
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {7'b0, bus.in_ready}, 8'h01);

    // Back-to-back accepts: inputs change right after each edge
    for (int i = 0; i < 11; i++) begin
      drive(vec[i].a, vec[i].b, vec[i].op, vec[i].use_acc);
      tick();
      chk($sformatf("vec%0d_y", i), bus.y, vec[i].exp_y);
      chk($sformatf("vec%0d_valid", i),
          {7'b0, bus.out_valid}, 8'h01);
    end

    // Backpressure: load 0x12, then stall three cycles
    drive(8'h12, 8'h00, 3'b111, 1'b0);
    tick();
    chk("bp_load_y", bus.y, 8'h12);
    bus.out_ready = 1'b0;
    drive(8'h99, 8'h66, 3'b111, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_in_ready", i),
          {7'b0, bus.in_ready}, 8'h00);
      tick();
      chk($sformatf("bp%0d_y", i), bus.y, 8'h12);
      chk($sformatf("bp%0d_valid", i),
          {7'b0, bus.out_valid}, 8'h01);
    end
    bus.out_ready = 1'b1;
    drive(8'h99, 8'h00, 3'b111, 1'b1);
    #1;
    chk("bp_release_in_ready", {7'b0, bus.in_ready}, 8'h01);
    tick();
    chk("bp_acc_held_y", bus.y, 8'h12);

    // Drain with no new input
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("drain_y_hold", bus.y, 8'h12);

`ifdef LOGIC_UNIT_FLAGS_EN
    drive(8'h0F, 8'h0F, 3'b010, 1'b0);
    tick();
    chk("flag0_y", bus.y, 8'h00);
    chk("flag0_zero", {7'b0, bus.zero}, 8'h01);
    chk("flag0_parity", {7'b0, bus.parity}, 8'h00);
    drive(8'h07, 8'h00, 3'b111, 1'b0);
    tick();
    chk("flag1_y", bus.y, 8'h07);
    chk("flag1_zero", {7'b0, bus.zero}, 8'h00);
    chk("flag1_parity", {7'b0, bus.parity}, 8'h01);
    bus.in_valid = 1'b0;
`endif

    // Reset while stalled; rst outranks a concurrent accept
    drive(8'h5A, 8'h00, 3'b111, 1'b0);
    tick();
    chk("rs_load_y", bus.y, 8'h5A);
    bus.out_ready = 1'b0;
    drive(8'hC3, 8'h00, 3'b111, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rs_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("rs_y", bus.y, 8'h00);
    #1;
    chk("rs_in_ready", {7'b0, bus.in_ready}, 8'h01);
    bus.out_ready = 1'b1;
    drive(8'hFF, 8'h00, 3'b111, 1'b1);
    tick();
    chk("rs_acc_y", bus.y, 8'h00);
    chk("rs_acc_valid", {7'b0, bus.out_valid}, 8'h01);
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_acc.md
# logic_unit_acc

Parametrised, pipelined successor to the 8-bit combinational logic unit. It performs one of eight bitwise operations on two WIDTH-bit operands. The result is registered behind a valid/ready handshake. An internal accumulator can stand in for operand A, so operations can be chained. The block sits between the operand/decode stage and the datapath writeback. Its op encoding stays compatible with the original 2-bit select when op[2]=0.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (>=1)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- in_valid  input  1  operand transaction offered
- in_ready  output  1  block can accept a transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- use_acc  input  1  1: the accumulator replaces operand A
- out_valid  output  1  y holds an unconsumed result
- out_ready  input  1  downstream accepts the result
- y  output  WIDTH  registered result
- zero  output  1  exists only with LOGIC_UNIT_FLAGS_EN; registered, y == 0
- parity  output  1  exists only with LOGIC_UNIT_FLAGS_EN; registered XOR-reduce of y

## Operation
- Effective operand: ea = use_acc ? acc : a. acc is an internal WIDTH-bit register.
- Base result r0 selected by op[1:0]:
  - 00: ea | b
  - 01: ea & b
  - 10: ea ^ b
  - 11: ~ea
- Final result: r = op[2] ? ~r0 : r0. This gives:
  - 100 NOR
  - 101 NAND
  - 110 XNOR
  - 111 pass ea
- Accept condition: acc_fire = in_valid & in_ready.
- in_ready = ~out_valid | out_ready. This is combinational from out_ready, so the block sustains full throughput with no bubble.
- On acc_fire, in the same clock edge:
  - y <= r
  - acc <= r
  - out_valid <= 1
  - with flags enabled: zero <= (r==0), parity <= ^r
- Output drain: out_valid & out_ready with no acc_fire clears out_valid; y keeps its value.
- Simultaneous drain and accept: the new result replaces the old one; out_valid stays 1.
- Stall: out_valid=1 and out_ready=0 gives in_ready=0. y, flags and acc hold, and the inputs are ignored.
- acc changes only on acc_fire. There is no separate clear; loading acc with a value uses op=111, use_acc=0.
- All arithmetic is bitwise, with no carries and no width growth.

## Timing
- Latency: 1 cycle. A transaction accepted at edge N presents y at edge N, visible in cycle N+1.
- Chaining: back-to-back accepts with use_acc=1 see the previous result in the very next cycle, with no hazard.
- Reset values: out_valid=0, y=0, acc=0, zero=0, parity=0.
- in_ready reads 1 in the cycle after reset.
- Reset while a result is held: the result is discarded and out_valid=0 at the next edge. rst takes priority over acc_fire in the same cycle.
- No combinational path from a/b/op/in_valid to any output. The only combinational path is out_ready -> in_ready.

## Configuration
- LOGIC_UNIT_FLAGS_EN:
  - Defined: the zero and parity ports and their registers exist. They update only on acc_fire and reset to 0.
  - Undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset, then a=0xF0, b=0x3C with op=000, 001, 010, 011 on consecutive cycles, out_ready=1. Expected y = 0xFC, 0x30, 0xCC, 0x0F, each one cycle after its accept; out_valid stays high.
- Inverted ops on the same operands with op=100, 101, 110, 111. Expected y = 0x03, 0xCF, 0x33, 0xF0.
- Accumulator chain:
  - op=111, a=0xAA, use_acc=0 gives y=0xAA.
  - Then use_acc=1, op=010, b=0xFF gives y=0x55.
  - Then use_acc=1, op=001, b=0x0F gives y=0x05.
- Backpressure: hold out_ready=0 for 3 cycles after one accept. Expected: in_ready=0, y and acc stable, extra in_valid ignored. After out_ready=1, the next transaction is accepted in that same cycle.
- Reset mid-stall with out_valid=1: rst for 1 cycle gives out_valid=0, y=0, acc=0. A following op=111, use_acc=1 gives y=0x00.
- With LOGIC_UNIT_FLAGS_EN: a=0x0F, b=0x0F, op=010 gives y=0x00, zero=1, parity=0. Then op=111, a=0x07 gives zero=0, parity=1.
